wb_arbiter: RTL and testbench

//  Writer side of the architectural register file's single write port. Accepts

---
 rtl/wb_arbiter_if.sv | 26 ++
 rtl/wb_arbiter.sv | 99 +++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Result-source handshakes and register-file write port of the writeback arbiter.
// The functional-unit side uses the master modport; the arbiter uses the slave modport.
interface wb_arbiter_if #(
    parameter int NSRC = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NSRC-1:0]    src_valid;
    logic [NSRC*AW-1:0] src_rd;
    logic [NSRC*DW-1:0] src_data;
    logic [NSRC-1:0]    src_ready;
    logic [AW-1:0]      rd_wb;
    logic               reg_write_en;
    logic [DW-1:0]      reg_write_data;
    logic [2**AW-1:0]   pend_mask;

    modport master (
        output src_valid, src_rd, src_data,
        input  src_ready, rd_wb, reg_write_en, reg_write_data, pend_mask
    );

    modport slave (
        input  src_valid, src_rd, src_data,
        output src_ready, rd_wb, reg_write_en, reg_write_data, pend_mask
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry buffer per result source, retired oldest-first
// through the single register-file write port, with a pending-destination mask.
module wb_arbiter #(
    parameter int NSRC = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic         aclk,
    input  logic         aresetn,
    wb_arbiter_if.slave  bus
);
    logic [NSRC-1:0] occ_r;
    logic [AW-1:0]   rd_r    [NSRC];
    logic [DW-1:0]   data_r  [NSRC];
    // older_r[i][j] set means entry i was accepted before entry j
    logic [NSRC-1:0] older_r [NSRC];

    logic [NSRC-1:0]  grant_s;
    logic [NSRC-1:0]  accept_s;
    logic [AW-1:0]    wr_rd_s;
    logic [DW-1:0]    wr_data_s;
    logic [2**AW-1:0] pend_s;

    // Grant the occupied entry that no other occupied entry is older than
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic blocked_v;
            blocked_v = 1'b0;
            for (int j = 0; j < NSRC; j++) begin
                blocked_v = blocked_v | (occ_r[j] & older_r[j][i] & (i != j));
            end
            grant_s[i] = occ_r[i] & ~blocked_v;
        end
    end

    assign bus.src_ready = ~occ_r | grant_s;
    assign accept_s      = bus.src_valid & bus.src_ready;

    // Mux the granted entry onto the write port; zero when nothing is granted
    always_comb begin
        wr_rd_s   = '0;
        wr_data_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            wr_rd_s   = wr_rd_s   | (rd_r[i]   & {AW{grant_s[i]}});
            wr_data_s = wr_data_s | (data_r[i] & {DW{grant_s[i]}});
        end
    end

    assign bus.rd_wb          = wr_rd_s;
    assign bus.reg_write_data = wr_data_s;
    // A granted r0 entry still yields a zero index, so a non-zero index implies a grant
    assign bus.reg_write_en   = (wr_rd_s != {AW{1'b0}});

    // Decode buffered destinations into the hazard mask
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < NSRC; i++) begin
            pend_s = pend_s | ({{(2**AW-1){1'b0}}, occ_r[i]} << rd_r[i]);
        end
    end

    assign bus.pend_mask = {pend_s[2**AW-1:1], 1'b0};

    // Entry capture, occupancy and relative-age bookkeeping
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            occ_r <= '0;
            for (int i = 0; i < NSRC; i++) begin
                rd_r[i]    <= '0;
                data_r[i]  <= '0;
                older_r[i] <= '0;
            end
        end else begin
            occ_r <= (occ_r & ~grant_s) | accept_s;
            for (int i = 0; i < NSRC; i++) begin
                if (accept_s[i]) begin
                    rd_r[i]   <= bus.src_rd[i*AW +: AW];
                    data_r[i] <= bus.src_data[i*DW +: DW];
                    for (int j = 0; j < NSRC; j++) begin
                        if (j != i) begin
                            if (accept_s[j]) begin
                                // Same-cycle acceptance: lower index counts as older
                                older_r[i][j] <= (i < j);
                                older_r[j][i] <= (j < i);
                            end else if (occ_r[j] && !grant_s[j]) begin
                                older_r[j][i] <= 1'b1;
                                older_r[i][j] <= 1'b0;
                            end else begin
                                older_r[j][i] <= 1'b0;
                                older_r[i][j] <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against an acceptance-order queue model.
module tb_wb_arbiter;
    localparam int NSRC = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    wb_arbiter_if #(.NSRC(NSRC), .DW(DW), .AW(AW)) bus();

    wb_arbiter #(.NSRC(NSRC), .DW(DW), .AW(AW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        int            src;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   model_ok = 1'b0;

    logic [NSRC-1:0]  exp_ready;
    logic             exp_en;
    logic [AW-1:0]    exp_rd;
    logic [DW-1:0]    exp_data;
    logic [2**AW-1:0] exp_mask;

    logic [DW-1:0] ref_rf [2**AW];
    logic [DW-1:0] dut_rf [2**AW];
    logic [AW-1:0] log_rd[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];

    logic          smp_en   = 1'b0;
    logic [AW-1:0] smp_rd   = '0;
    logic [DW-1:0] smp_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs from the queue: head is granted, every other queued source is busy
    always @(negedge aclk) begin
        if (model_ok) begin
            exp_ready = '1;
            exp_mask  = '0;
            exp_en    = 1'b0;
            exp_rd    = '0;
            exp_data  = '0;
            for (int k = 0; k < q.size(); k++) begin
                if (k > 0) exp_ready[q[k].src] = 1'b0;
                if (q[k].rd != 0) exp_mask[q[k].rd] = 1'b1;
            end
            if (q.size() > 0) begin
                exp_rd   = q[0].rd;
                exp_data = q[0].data;
                exp_en   = (q[0].rd != 0);
            end
            chk("src_ready", 64'(bus.src_ready), 64'(exp_ready));
            chk("reg_write_en", 64'(bus.reg_write_en), 64'(exp_en));
            chk("rd_wb", 64'(bus.rd_wb), 64'(exp_rd));
            chk("reg_write_data", 64'(bus.reg_write_data), 64'(exp_data));
            chk("pend_mask", 64'(bus.pend_mask), 64'(exp_mask));
            smp_en   = bus.reg_write_en;
            smp_rd   = bus.rd_wb;
            smp_data = bus.reg_write_data;
        end
    end

    // Advance the model and both register files at each clock edge
    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (smp_en) begin
                dut_rf[smp_rd] = smp_data;
                log_rd.push_back(smp_rd);
                log_data.push_back(smp_data);
                log_cyc.push_back(cyc);
            end
            if (q.size() > 0) begin
                if (q[0].rd != 0) ref_rf[q[0].rd] = q[0].data;
                void'(q.pop_front());
            end
            for (int i = 0; i < NSRC; i++) begin
                if (bus.src_valid[i] && exp_ready[i]) begin
                    ent_t e;
                    e.src  = i;
                    e.rd   = bus.src_rd[i*AW +: AW];
                    e.data = bus.src_data[i*DW +: DW];
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [AW-1:0] r0, r1, r2,
                         input logic [DW-1:0] d0, d1, d2);
        bus.src_valid = v;
        bus.src_rd    = {r2, r1, r0};
        bus.src_data  = {d2, d1, d0};
    endtask

    task automatic idle();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic clear_log();
        log_rd.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    initial begin
        for (int r = 0; r < 2**AW; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end

        // Reset held two clocks with every source valid
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        aresetn = 1'b0;
        step(2);
        aresetn = 1'b1;
        idle();
        @(negedge aclk);
        chk("rst_ready", 64'(bus.src_ready), 64'(3'b111));
        chk("rst_pend", 64'(bus.pend_mask), 64'd0);
        chk("rst_en", 64'(bus.reg_write_en), 64'd0);
        step(1);

        // Single ALU result
        drive(3'b001, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h0, 32'h0);
        step(1);
        idle();
        @(negedge aclk);
        chk("single_en", 64'(bus.reg_write_en), 64'd1);
        chk("single_rd", 64'(bus.rd_wb), 64'd5);
        chk("single_data", 64'(bus.reg_write_data), 64'h1234_5678);
        chk("single_pend5", 64'(bus.pend_mask[5]), 64'd1);
        step(3);
        @(negedge aclk);
        chk("single_idle_pend", 64'(bus.pend_mask), 64'd0);
        step(1);

        // Three sources in the same cycle
        clear_log();
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3);
        step(1);
        idle();
        @(negedge aclk);
        chk("tie_ready21", 64'(bus.src_ready[2:1]), 64'(2'b00));
        step(4);
        chk("tie_count", 64'(log_rd.size()), 64'd3);
        if (log_rd.size() >= 3) begin
            chk("tie_rd0", 64'(log_rd[0]), 64'd1);
            chk("tie_rd1", 64'(log_rd[1]), 64'd2);
            chk("tie_rd2", 64'(log_rd[2]), 64'd3);
            chk("tie_span", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
        end

        // Write-after-write to r7 from MDU then ALU
        clear_log();
        drive(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA);
        step(1);
        drive(3'b001, 5'd7, 5'd0, 5'd0, 32'hB, 32'h0, 32'h0);
        step(1);
        idle();
        step(3);
        chk("waw_final", 64'(dut_rf[7]), 64'hB);
        chk("waw_count", 64'(log_data.size()), 64'd2);
        if (log_data.size() >= 2) begin
            chk("waw_first", 64'(log_data[0]), 64'hA);
            chk("waw_second", 64'(log_data[1]), 64'hB);
        end

        // r0 destination from LSU
        clear_log();
        drive(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);
        step(1);
        idle();
        @(negedge aclk);
        chk("r0_en", 64'(bus.reg_write_en), 64'd0);
        chk("r0_pend", 64'(bus.pend_mask), 64'd0);
        step(1);
        @(negedge aclk);
        chk("r0_freed", 64'(bus.src_ready), 64'(3'b111));
        step(1);
        chk("r0_nowrite", 64'(log_rd.size()), 64'd0);

        // ALU streaming every cycle
        clear_log();
        for (int k = 0; k < 10; k++) begin
            drive(3'b001, 5'(10 + k), 5'd0, 5'd0, 32'(k + 1), 32'h0, 32'h0);
            @(negedge aclk);
            chk("stream_ready", 64'(bus.src_ready[0]), 64'd1);
            @(posedge aclk);
            #1;
        end
        idle();
        step(2);
        chk("stream_count", 64'(log_rd.size()), 64'd10);
        if (log_rd.size() >= 10) chk("stream_span", 64'(log_cyc[9] - log_cyc[0]), 64'd9);

        // Reset with two entries buffered
        clear_log();
        drive(3'b011, 5'd20, 5'd21, 5'd0, 32'h55, 32'h66, 32'h0);
        step(1);
        idle();
        aresetn = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(3);
        chk("midrst_count", 64'(log_rd.size()), 64'd0);
        chk("midrst_r20", 64'(dut_rf[20]), 64'd0);
        chk("midrst_r21", 64'(dut_rf[21]), 64'd0);

        // Random traffic with a narrow register range to provoke WAW and r0 cases
        for (int n = 0; n < 400; n++) begin
            drive(3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  32'($urandom), 32'($urandom), 32'($urandom));
            aresetn = ($urandom_range(0, 99) != 0);
            step(1);
        end
        aresetn = 1'b1;
        idle();
        step(5);
        for (int r = 0; r < 2**AW; r++) begin
            chk("rf_final", 64'(dut_rf[r]), 64'(ref_rf[r]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
